// File: rtl/operand_stack_if.sv
// Operation/status bundle between the control unit (master) and the operand stack (slave).
// The control unit drives the op fields; the stack returns tos/nos, occupancy and the error flags.
interface operand_stack_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic              op_valid;
  logic [2:0]        op;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] tos;
  logic [DATA_W-1:0] nos;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output op_valid, op, din,
    input  tos, nos, count, empty, full, ovf_err, unf_err
  );

  modport slave (
    input  op_valid, op, din,
    output tos, nos, count, empty, full, ovf_err, unf_err
  );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack: one op per cycle, combinational tos/nos, sticky overflow/underflow flags.
// Illegal ops leave the count and the array untouched and only raise their flag.
module operand_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  operand_stack_if.slave    bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_PUSH    = 3'b001,
    OP_POP     = 3'b010,
    OP_DUP     = 3'b011,
    OP_SWAP    = 3'b100,
    OP_REPL2   = 3'b101,
    OP_REPL1   = 3'b110,
    OP_CLR_ERR = 3'b111
  } op_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [AW-1:0]     push_idx, top_idx, nos_idx;
  logic [DATA_W-1:0] tos_val, nos_val;
  logic              is_empty, is_full, lt2;

  // Up to two array writes per cycle: SWAP needs both, everything else uses port 0.
  logic              wr0_en, wr1_en;
  logic [AW-1:0]     wr0_idx, wr1_idx;
  logic [DATA_W-1:0] wr0_data, wr1_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign lt2      = (count_q < CNT_W'(2));

  assign push_idx = AW'(count_q);
  assign top_idx  = AW'(count_q - CNT_W'(1));
  assign nos_idx  = AW'(count_q - CNT_W'(2));

  assign tos_val  = is_empty ? '0 : mem_q[top_idx];
  assign nos_val  = lt2      ? '0 : mem_q[nos_idx];

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    wr0_en   = 1'b0;
    wr0_idx  = push_idx;
    wr0_data = bus.din;
    wr1_en   = 1'b0;
    wr1_idx  = nos_idx;
    wr1_data = tos_val;

    if (bus.op_valid && !reset) begin
      case (op_e'(bus.op))
        OP_PUSH: begin
          if (is_full) ovf_d = 1'b1;
          else begin
            wr0_en  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
        OP_POP: begin
          if (is_empty) unf_d = 1'b1;
          else count_d = count_q - CNT_W'(1);
        end
        OP_DUP: begin
          if (is_full) ovf_d = 1'b1;
          else if (is_empty) unf_d = 1'b1;
          else begin
            wr0_en   = 1'b1;
            wr0_data = tos_val;
            count_d  = count_q + CNT_W'(1);
          end
        end
        OP_SWAP: begin
          if (lt2) unf_d = 1'b1;
          else begin
            wr0_en   = 1'b1;
            wr0_idx  = top_idx;
            wr0_data = nos_val;
            wr1_en   = 1'b1;
          end
        end
        OP_REPL2: begin
          if (lt2) unf_d = 1'b1;
          else begin
            wr0_en  = 1'b1;
            wr0_idx = nos_idx;
            count_d = count_q - CNT_W'(1);
          end
        end
        OP_REPL1: begin
          if (is_empty) unf_d = 1'b1;
          else begin
            wr0_en  = 1'b1;
            wr0_idx = top_idx;
          end
        end
        OP_CLR_ERR: begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: the array has no reset; entries above count are never observed, so clearing them is wasted logic.
  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[wr0_idx] <= wr0_data;
    if (wr1_en) mem_q[wr1_idx] <= wr1_data;
  end

  assign bus.tos     = tos_val;
  assign bus.nos     = nos_val;
  assign bus.count   = count_q;
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: each task drives one scenario and checks hand-computed values.
module tb_operand_stack;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_DUP     = 3'b011;
  localparam logic [2:0] OP_SWAP    = 3'b100;
  localparam logic [2:0] OP_REPL2   = 3'b101;
  localparam logic [2:0] OP_REPL1   = 3'b110;
  localparam logic [2:0] OP_CLR_ERR = 3'b111;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  operand_stack_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  operand_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one op across a rising edge and return #1 after it.
  task automatic do_op(input logic [2:0] o, input logic [DATA_W-1:0] d);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.din      = d;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.din      = '0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %0b expected 1", bus.empty); end
    tests_run++; if (bus.full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %0b expected 0", bus.full); end
    tests_run++; if (bus.tos !== 8'd0 || bus.nos !== 8'd0) begin tests_failed++; $display("FAIL reset_tos_nos: got tos=%0d nos=%0d expected 0/0", bus.tos, bus.nos); end
    tests_run++; if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got ovf=%0b unf=%0b expected 0/0", bus.ovf_err, bus.unf_err); end
  endtask

  task automatic test_push_pop();
    do_reset();
    do_op(OP_PUSH, 8'd5);
    tests_run++; if (bus.count !== 5'd1) begin tests_failed++; $display("FAIL push5_count: got %0d expected 1", bus.count); end
    tests_run++; if (bus.tos !== 8'd5) begin tests_failed++; $display("FAIL push5_tos: got %0d expected 5", bus.tos); end
    tests_run++; if (bus.nos !== 8'd0) begin tests_failed++; $display("FAIL push5_nos: got %0d expected 0", bus.nos); end
    tests_run++; if (bus.empty !== 1'b0) begin tests_failed++; $display("FAIL push5_empty: got %0b expected 0", bus.empty); end
    do_op(OP_PUSH, 8'd7);
    do_op(OP_PUSH, 8'd12);
    tests_run++; if (bus.tos !== 8'd12 || bus.nos !== 8'd7) begin tests_failed++; $display("FAIL prepop_tos_nos: got tos=%0d nos=%0d expected 12/7", bus.tos, bus.nos); end
    do_op(OP_POP, 8'd0);
    tests_run++; if (bus.count !== 5'd2) begin tests_failed++; $display("FAIL pop_count: got %0d expected 2", bus.count); end
    tests_run++; if (bus.tos !== 8'd7 || bus.nos !== 8'd5) begin tests_failed++; $display("FAIL pop_tos_nos: got tos=%0d nos=%0d expected 7/5", bus.tos, bus.nos); end
    // op_valid low: PUSH code must be ignored
    bus.op_valid = 1'b0; bus.op = OP_PUSH; bus.din = 8'd77;
    @(posedge clk); #1;
    bus.op = OP_NOP;
    tests_run++; if (bus.count !== 5'd2 || bus.tos !== 8'd7) begin tests_failed++; $display("FAIL invalid_ignored: got count=%0d tos=%0d expected 2/7", bus.count, bus.tos); end
  endtask

  task automatic test_swap_repl();
    do_reset();
    do_op(OP_PUSH, 8'd3);
    do_op(OP_PUSH, 8'd4);
    do_op(OP_SWAP, 8'd0);
    tests_run++; if (bus.tos !== 8'd3 || bus.nos !== 8'd4) begin tests_failed++; $display("FAIL swap: got tos=%0d nos=%0d expected 3/4", bus.tos, bus.nos); end
    tests_run++; if (bus.count !== 5'd2) begin tests_failed++; $display("FAIL swap_count: got %0d expected 2", bus.count); end
    do_op(OP_REPL2, 8'd7);
    tests_run++; if (bus.count !== 5'd1 || bus.tos !== 8'd7) begin tests_failed++; $display("FAIL repl2: got count=%0d tos=%0d expected 1/7", bus.count, bus.tos); end
    do_op(OP_REPL1, 8'd8);
    tests_run++; if (bus.count !== 5'd1 || bus.tos !== 8'd8) begin tests_failed++; $display("FAIL repl1: got count=%0d tos=%0d expected 1/8", bus.count, bus.tos); end
    do_op(OP_DUP, 8'd0);
    tests_run++; if (bus.count !== 5'd2 || bus.tos !== 8'd8 || bus.nos !== 8'd8) begin tests_failed++; $display("FAIL dup: got count=%0d tos=%0d nos=%0d expected 2/8/8", bus.count, bus.tos, bus.nos); end
    tests_run++; if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin tests_failed++; $display("FAIL legal_flags: got ovf=%0b unf=%0b expected 0/0", bus.ovf_err, bus.unf_err); end
  endtask

  task automatic test_full_ovf();
    do_reset();
    for (int i = 1; i <= 15; i++) do_op(OP_PUSH, DATA_W'(i));
    tests_run++; if (bus.full !== 1'b0 || bus.count !== 5'd15) begin tests_failed++; $display("FAIL push15: got full=%0b count=%0d expected 0/15", bus.full, bus.count); end
    do_op(OP_PUSH, 8'd16);
    tests_run++; if (bus.full !== 1'b1 || bus.tos !== 8'd16 || bus.nos !== 8'd15) begin tests_failed++; $display("FAIL push16: got full=%0b tos=%0d nos=%0d expected 1/16/15", bus.full, bus.tos, bus.nos); end
    do_op(OP_PUSH, 8'd99);
    tests_run++; if (bus.count !== 5'd16 || bus.tos !== 8'd16) begin tests_failed++; $display("FAIL ovf_stack: got count=%0d tos=%0d expected 16/16", bus.count, bus.tos); end
    tests_run++; if (bus.ovf_err !== 1'b1 || bus.unf_err !== 1'b0) begin tests_failed++; $display("FAIL ovf_flags: got ovf=%0b unf=%0b expected 1/0", bus.ovf_err, bus.unf_err); end
    do_op(OP_CLR_ERR, 8'd0);
    tests_run++; if (bus.ovf_err !== 1'b0 || bus.count !== 5'd16 || bus.tos !== 8'd16) begin tests_failed++; $display("FAIL clr_err: got ovf=%0b count=%0d tos=%0d expected 0/16/16", bus.ovf_err, bus.count, bus.tos); end
    do_op(OP_DUP, 8'd0);
    tests_run++; if (bus.ovf_err !== 1'b1 || bus.count !== 5'd16) begin tests_failed++; $display("FAIL dup_full: got ovf=%0b count=%0d expected 1/16", bus.ovf_err, bus.count); end
    for (int k = 1; k <= 15; k++) begin
      do_op(OP_POP, 8'd0);
      tests_run++; if (bus.tos !== DATA_W'(16 - k)) begin tests_failed++; $display("FAIL drain_tos_%0d: got %0d expected %0d", k, bus.tos, 16 - k); end
    end
    do_op(OP_POP, 8'd0);
    tests_run++; if (bus.empty !== 1'b1 || bus.tos !== 8'd0 || bus.count !== 5'd0) begin tests_failed++; $display("FAIL pop_last: got empty=%0b tos=%0d count=%0d expected 1/0/0", bus.empty, bus.tos, bus.count); end
    tests_run++; if (bus.ovf_err !== 1'b1 || bus.unf_err !== 1'b0) begin tests_failed++; $display("FAIL ovf_sticky: got ovf=%0b unf=%0b expected 1/0", bus.ovf_err, bus.unf_err); end
  endtask

  task automatic test_underflow();
    do_reset();
    do_op(OP_POP, 8'd0);
    tests_run++; if (bus.unf_err !== 1'b1 || bus.count !== 5'd0) begin tests_failed++; $display("FAIL pop_empty: got unf=%0b count=%0d expected 1/0", bus.unf_err, bus.count); end
    do_op(OP_PUSH, 8'd9);
    do_op(OP_SWAP, 8'd0);
    tests_run++; if (bus.unf_err !== 1'b1 || bus.tos !== 8'd9 || bus.count !== 5'd1) begin tests_failed++; $display("FAIL swap_one: got unf=%0b tos=%0d count=%0d expected 1/9/1", bus.unf_err, bus.tos, bus.count); end
    do_op(OP_CLR_ERR, 8'd0);
    tests_run++; if (bus.unf_err !== 1'b0) begin tests_failed++; $display("FAIL clr_unf: got %0b expected 0", bus.unf_err); end
    do_op(OP_REPL2, 8'd33);
    tests_run++; if (bus.unf_err !== 1'b1 || bus.tos !== 8'd9 || bus.count !== 5'd1) begin tests_failed++; $display("FAIL repl2_one: got unf=%0b tos=%0d count=%0d expected 1/9/1", bus.unf_err, bus.tos, bus.count); end
    do_op(OP_CLR_ERR, 8'd0);
    do_op(OP_POP, 8'd0);
    do_op(OP_REPL1, 8'd44);
    tests_run++; if (bus.unf_err !== 1'b1 || bus.count !== 5'd0 || bus.tos !== 8'd0) begin tests_failed++; $display("FAIL repl1_empty: got unf=%0b count=%0d tos=%0d expected 1/0/0", bus.unf_err, bus.count, bus.tos); end
    do_op(OP_CLR_ERR, 8'd0);
    do_op(OP_DUP, 8'd0);
    tests_run++; if (bus.unf_err !== 1'b1 || bus.ovf_err !== 1'b0 || bus.count !== 5'd0) begin tests_failed++; $display("FAIL dup_empty: got unf=%0b ovf=%0b count=%0d expected 1/0/0", bus.unf_err, bus.ovf_err, bus.count); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    do_op(OP_PUSH, 8'd1);
    do_op(OP_PUSH, 8'd2);
    do_op(OP_PUSH, 8'd3);
    do_op(OP_POP, 8'd0);
    do_op(OP_POP, 8'd0);
    do_op(OP_POP, 8'd0);
    do_op(OP_POP, 8'd0);  // underflow so the flag has something to clear
    do_op(OP_PUSH, 8'd1);
    do_op(OP_PUSH, 8'd2);
    do_op(OP_PUSH, 8'd3);
    tests_run++; if (bus.count !== 5'd3 || bus.unf_err !== 1'b1) begin tests_failed++; $display("FAIL prerst_state: got count=%0d unf=%0b expected 3/1", bus.count, bus.unf_err); end
    reset = 1'b1; bus.op_valid = 1'b1; bus.op = OP_PUSH; bus.din = 8'd55;
    @(posedge clk); #1;
    reset = 1'b0; bus.op_valid = 1'b0; bus.op = OP_NOP; bus.din = '0;
    tests_run++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin tests_failed++; $display("FAIL rst_prio_count: got count=%0d empty=%0b expected 0/1", bus.count, bus.empty); end
    tests_run++; if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin tests_failed++; $display("FAIL rst_prio_flags: got ovf=%0b unf=%0b expected 0/0", bus.ovf_err, bus.unf_err); end
    tests_run++; if (bus.tos !== 8'd0) begin tests_failed++; $display("FAIL rst_prio_tos: got %0d expected 0", bus.tos); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.din      = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_push_pop();
    test_swap_repl();
    test_full_ovf();
    test_underflow();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- LIFO operand stack for the stack-based processor.
- Sits directly downstream of the control unit, which issues one stack operation per cycle: push immediate/RAM/temp1 value, pop to RAM, or replace operands with an ALU result.
- Exposes top-of-stack (tos) and next-on-stack (nos) combinationally to the ALU and RAM write path.
- Reports occupancy, empty/full, and sticky overflow/underflow errors.

Parameters:
- DATA_W, 8, width of each stack entry.
- DEPTH, 16, number of entries; power of two, ≥ 2.
- CNT_W, 5, width of count; must hold 0..DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  op is executed on this rising edge when high.
- op  input  3  operation code (see Behaviour).
- din  input  DATA_W  data for PUSH/REPL2/REPL1.
- tos  output  DATA_W  entry at count-1; 0 when count=0.
- nos  output  DATA_W  entry at count-2; 0 when count<2.
- count  output  CNT_W  number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- ovf_err  output  1  sticky overflow flag.
- unf_err  output  1  sticky underflow flag.

Behaviour:
- Reset (synchronous, has priority over any op in the same cycle):
  - count=0, ovf_err=0, unf_err=0.
  - Array contents are don't-care; tos=nos=0, empty=1, full=0 follow from count=0.
- All state updates occur on the rising edge with op_valid=1. op is ignored when op_valid=0.
- tos/nos/empty/full are combinational from count and the array, valid the cycle after the op edge (zero-cycle read latency).
- Op codes:
  - 000 NOP: no change.
  - 001 PUSH: stack[count]<=din; count+1.
  - 010 POP: count-1; the popped value is read from tos before the edge.
  - 011 DUP: stack[count]<=tos; count+1.
  - 100 SWAP: exchange stack[count-1] and stack[count-2]; count unchanged.
  - 101 REPL2: stack[count-2]<=din; count-1. Used for binary ALU results (two operands in, one result).
  - 110 REPL1: stack[count-1]<=din; count unchanged. Used for unary ALU results.
  - 111 CLR_ERR: ovf_err<=0, unf_err<=0; the stack is untouched.
- Error rules. An illegal op leaves count and the array unchanged and sets its sticky flag:
  - PUSH or DUP when full: ovf_err<=1.
  - POP, DUP or REPL1 when count=0: unf_err<=1.
  - SWAP or REPL2 when count<2: unf_err<=1.
- Flags clear only on reset or CLR_ERR.
- Legal ops never affect the flags.
- Boundaries:
  - PUSH at count=DEPTH-1 makes full=1 on the next cycle.
  - POP at count=1 makes empty=1 and tos=0.
  - count never wraps: no increment past DEPTH, no decrement below 0.
- No internal FSM beyond the count register and flags. Each op is single-cycle; there is no backpressure.

Test Plan:
- Reset, then PUSH din=5 -> count=1, tos=5, nos=0, empty=0.
- PUSH 7, PUSH 12, then POP -> tos=12 before the POP edge; after it count=2, tos=7, nos=5.
- With stack [3,4] (tos=4), SWAP -> tos=3, nos=4. Then REPL2 din=7 -> count=1, tos=7. Then REPL1 din=8 -> tos=8, count=1.
- 16 PUSHes of values 1..16 -> full=1, tos=16. A 17th PUSH din=99 -> count=16, tos=16, ovf_err=1. Then CLR_ERR -> ovf_err=0, stack unchanged.
- From reset: POP -> unf_err=1, count=0. SWAP with count=1 -> unf_err stays 1, tos unchanged.
- With count=3, assert reset together with op_valid=1, op=PUSH -> the next cycle shows count=0, empty=1, flags=0, and the push is dropped.
